// File: rtl/enemy_track_predictor_if.sv
// enemy_track_predictor_if: detector-in / aim-out bus of the enemy track predictor
interface enemy_track_predictor_if;
    logic        v_sync;
    logic [15:0] x_real_in;
    logic [15:0] y_real_in;
    logic        red_detect_in;
    logic [15:0] x_predict_out;
    logic [15:0] y_predict_out;
    logic        red_detect_spi_out;
    logic [1:0]  state_out;
    logic        pred_valid_stb;
    modport master (
        output v_sync, x_real_in, y_real_in, red_detect_in,
        input  x_predict_out, y_predict_out, red_detect_spi_out, state_out, pred_valid_stb
    );
    // v_sync is carried only for drop-in compatibility; the predictor never reads it
    modport slave (
        input  x_real_in, y_real_in, red_detect_in,
        output x_predict_out, y_predict_out, red_detect_spi_out, state_out, pred_valid_stb
    );
endinterface

// File: rtl/enemy_track_predictor.sv
// enemy_track_predictor: tick-sampled IDLE/ACQUIRE/TRACK/COAST tracker with EMA velocity and clamped lead aim
module enemy_track_predictor #(
    parameter int SAMPLE_CYCLES = 20_000_000,
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479,
    parameter int CENTER_X      = 320,
    parameter int CENTER_Y      = 240,
    parameter int VMAX          = 16,
    parameter int V_EMA_SHIFT   = 3,
    parameter int DECAY_SHIFT   = 4,
    parameter int ACQUIRE_HITS  = 3,
    parameter int GIVEUP_TICKS  = 10,
    parameter int LEAD_TICKS    = 2
) (
    input logic clk,
    input logic reset,
    enemy_track_predictor_if.slave bus
);
    localparam int CW = $clog2(SAMPLE_CYCLES);
    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, COAST} state_t;
    state_t state, n_state;
    logic [CW-1:0] cnt;
    logic cnt_hit, sample_stb;
    logic [15:0] est_x, est_y, prev_x, prev_y, n_est_x, n_est_y, n_prev_x, n_prev_y;
    logic signed [15:0] vx, vy, n_vx, n_vy;
    logic prev_valid, n_prev_valid, held;
    logic [3:0] hit_cnt, n_hit_cnt;
    logic [7:0] miss_cnt, n_miss_cnt, miss_inc;

    function automatic logic [15:0] clamp(input int t, input int mx);
        return 16'(t < 0 ? 0 : (t > mx ? mx : t));
    endfunction

    function automatic logic signed [15:0] ema(input logic [15:0] meas, input logic [15:0] prev,
                                               input logic signed [15:0] v);
        int m;
        m = int'(meas) - int'(prev);
        m = m > VMAX ? VMAX : (m < -VMAX ? -VMAX : m);
        return 16'(int'(v) + ((m - int'(v)) >>> V_EMA_SHIFT));
    endfunction

    function automatic logic signed [15:0] decay(input logic signed [15:0] v);
        return v - (v >>> DECAY_SHIFT);
    endfunction

    always_comb begin
        n_state      = state;
        n_est_x      = est_x;
        n_est_y      = est_y;
        n_prev_x     = prev_x;
        n_prev_y     = prev_y;
        n_prev_valid = prev_valid;
        n_vx         = vx;
        n_vy         = vy;
        n_hit_cnt    = hit_cnt;
        n_miss_cnt   = miss_cnt;
        miss_inc     = state == TRACK ? 8'd1 : miss_cnt + 8'd1;
        if (bus.red_detect_in) begin
            n_est_x      = bus.x_real_in;
            n_est_y      = bus.y_real_in;
            n_prev_x     = bus.x_real_in;
            n_prev_y     = bus.y_real_in;
            n_prev_valid = 1'b1;
            n_miss_cnt   = '0;
            n_vx         = state == IDLE ? '0 : (prev_valid ? ema(bus.x_real_in, prev_x, vx) : vx);
            n_vy         = state == IDLE ? '0 : (prev_valid ? ema(bus.y_real_in, prev_y, vy) : vy);
            n_hit_cnt    = state == IDLE ? 4'd1 : (state == ACQUIRE ? hit_cnt + 4'd1 : hit_cnt);
            n_state      = (state == IDLE || state == ACQUIRE) && n_hit_cnt != 4'(ACQUIRE_HITS) ? ACQUIRE : TRACK;
        end else if (state == ACQUIRE) begin
            n_state      = IDLE;
            n_vx         = '0;
            n_vy         = '0;
            n_hit_cnt    = '0;
            n_prev_valid = 1'b0;
        end else if (state != IDLE) begin
            n_prev_valid = 1'b0;
            if (miss_inc == 8'(GIVEUP_TICKS)) begin
                n_state    = IDLE;
                n_vx       = '0;
                n_vy       = '0;
                n_est_x    = 16'(CENTER_X);
                n_est_y    = 16'(CENTER_Y);
                n_hit_cnt  = '0;
                n_miss_cnt = '0;
            end else begin
                n_state    = COAST;
                n_miss_cnt = miss_inc;
                n_est_x    = clamp(int'(est_x) + int'(vx), X_MAX);
                n_est_y    = clamp(int'(est_y) + int'(vy), Y_MAX);
                n_vx       = decay(vx);
                n_vy       = decay(vy);
            end
        end
        held = n_state == TRACK || n_state == COAST;
    end

    // outputs are computed from the post-update state so they land one cycle after sample_stb
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt                    <= '0;
            cnt_hit                <= 1'b0;
            sample_stb             <= 1'b0;
            state                  <= IDLE;
            est_x                  <= '0;
            est_y                  <= '0;
            prev_x                 <= '0;
            prev_y                 <= '0;
            prev_valid             <= 1'b0;
            vx                     <= '0;
            vy                     <= '0;
            hit_cnt                <= '0;
            miss_cnt               <= '0;
            bus.x_predict_out      <= 16'(CENTER_X);
            bus.y_predict_out      <= 16'(CENTER_Y);
            bus.red_detect_spi_out <= 1'b0;
            bus.state_out          <= IDLE;
            bus.pred_valid_stb     <= 1'b0;
        end else begin
            cnt                <= cnt == CW'(SAMPLE_CYCLES - 1) ? '0 : cnt + 1'b1;
            cnt_hit            <= cnt == CW'(SAMPLE_CYCLES - 1);
            sample_stb         <= cnt_hit;
            bus.pred_valid_stb <= sample_stb;
            if (sample_stb) begin
                state                  <= n_state;
                est_x                  <= n_est_x;
                est_y                  <= n_est_y;
                prev_x                 <= n_prev_x;
                prev_y                 <= n_prev_y;
                prev_valid             <= n_prev_valid;
                vx                     <= n_vx;
                vy                     <= n_vy;
                hit_cnt                <= n_hit_cnt;
                miss_cnt               <= n_miss_cnt;
                bus.x_predict_out      <= held ? clamp(int'(n_est_x) + int'(n_vx) * LEAD_TICKS, X_MAX) : 16'(CENTER_X);
                bus.y_predict_out      <= held ? clamp(int'(n_est_y) + int'(n_vy) * LEAD_TICKS, Y_MAX) : 16'(CENTER_Y);
                bus.red_detect_spi_out <= held;
                bus.state_out          <= n_state;
            end
        end
    end
endmodule

// File: doc/enemy_track_predictor.md
# enemy_track_predictor

Parametrised enemy-position predictor, the successor to the fixed 2 s predictor in the VGA tracking path. It sits between the red-blob detector and the SPI link to the motor controller. The block samples the detector on a programmable tick and runs an IDLE/ACQUIRE/TRACK/COAST state machine with multi-hit acquisition. It keeps an EMA velocity estimate and outputs a lead-compensated aim point LEAD_TICKS samples ahead, clamped to the screen.

## Interface
Parameters:
- SAMPLE_CYCLES, 20_000_000: clk cycles per sample tick (200 ms at 100 MHz); must be ≥ 4.
- X_MAX, 639: max x coordinate.
- Y_MAX, 479: max y coordinate.
- CENTER_X, 320: idle x output.
- CENTER_Y, 240: idle y output.
- VMAX, 16: per-tick velocity magnitude limit, pixels.
- V_EMA_SHIFT, 3: velocity EMA shift; 0 = raw measurement.
- DECAY_SHIFT, 4: velocity decay shift per coasted tick.
- ACQUIRE_HITS, 3: consecutive detections to enter TRACK, 1..15.
- GIVEUP_TICKS, 10: consecutive misses before dropping track, 1..255.
- LEAD_TICKS, 2: look-ahead horizon in ticks, 0..15.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- v_sync  in  1  unused; kept for drop-in compatibility.
- x_real_in  in  16  detected x.
- y_real_in  in  16  detected y.
- red_detect_in  in  1  detection valid.
- x_predict_out  out  16  predicted aim x.
- y_predict_out  out  16  predicted aim y.
- red_detect_spi_out  out  1  target held (TRACK or COAST).
- state_out  out  2  IDLE=0, ACQUIRE=1, TRACK=2, COAST=3.
- pred_valid_stb  out  1  one-cycle pulse when outputs update.

## Operation
**Tick generation**
- Counter runs 0..SAMPLE_CYCLES-1.
- sample_stb is registered high for one cycle after the count reaches SAMPLE_CYCLES-1.
- Inputs are sampled only when sample_stb is high.

**Internal state**
- est_x/est_y: unsigned 16-bit position estimate.
- vx/vy: signed 16-bit velocity.
- prev_x/prev_y with prev_valid: last measurement.
- hit_cnt, miss_cnt: hit and miss counters.

**Velocity update** (applied on a detection when prev_valid = 1)
- Measurement m = x_real_in − prev_x, computed signed, then clamped to ±VMAX.
- Update: v += (m − v) >>> V_EMA_SHIFT, using arithmetic shift.
- When prev_valid = 0, v is left unchanged.

**Every detection**
- Sets est := meas.
- Sets prev := meas and prev_valid := 1.
- Clears miss_cnt.

**States**
- IDLE:
  - Detection → ACQUIRE with hit_cnt = 1 and v = 0.
  - If ACQUIRE_HITS = 1, detection goes directly to TRACK instead.
- ACQUIRE:
  - Detection → hit_cnt++; when hit_cnt reaches ACQUIRE_HITS → TRACK.
  - Miss → IDLE; v, hit_cnt and prev_valid cleared.
- TRACK:
  - Detection → stay in TRACK.
  - Miss → COAST with miss_cnt = 1 and prev_valid = 0; extrapolate.
- COAST:
  - Detection → TRACK. v is kept and not updated on this tick, because prev_valid = 0.
  - Miss → miss_cnt++ and extrapolate.
  - When miss_cnt reaches GIVEUP_TICKS → IDLE; v = 0 and est = center.

**Extrapolate**
- est := clamp(est + v, 0..MAX).
- Then v := v − (v >>> DECAY_SHIFT).

**Outputs**
- In TRACK or COAST: out = clamp(est + v·LEAD_TICKS, 0..X_MAX / 0..Y_MAX), computed with 32-bit signed intermediates.
- In IDLE or ACQUIRE: out = CENTER.
- red_detect_spi_out = 1 only in TRACK or COAST.

## Timing
- Reset values:
  - x/y_predict_out = CENTER_X/CENTER_Y.
  - red_detect_spi_out = 0, state_out = 0, pred_valid_stb = 0.
  - All counters, v and prev_valid cleared.
- Reset asserted mid-operation takes effect immediately (asynchronous) and restarts the tick counter.
- First sample_stb occurs SAMPLE_CYCLES+1 cycles after reset deasserts.
- The state/estimate update happens on the cycle sample_stb is high.
- x/y_predict_out, red_detect_spi_out and state_out are registered and change one cycle later, together with pred_valid_stb. Latency is 1 cycle from sample_stb.
- pred_valid_stb fires on every tick, including in IDLE.
- Between ticks, all outputs hold their values and input changes are ignored.

## Test plan
Directed tests use SAMPLE_CYCLES=16, ACQUIRE_HITS=3, GIVEUP_TICKS=4, LEAD_TICKS=2, V_EMA_SHIFT=0, unless a scenario states otherwise.

1. **Reset:** assert reset → outputs 320/240, spi 0, state 0. Deassert → first pred_valid_stb at cycle 18.
2. **Acquire:** detections at x = 100, 104, 108 (y = 200) on ticks 1–3.
   - Ticks 1–2: output 320/240, spi 0, state 1.
   - Tick 3: state 2, vx = 4, x_out = 116, y_out = 200, spi 1.
3. **Abort:** detect, detect, miss → state 0, output 320/240, spi 0. A following detection restarts at hit_cnt = 1.
4. **Coast and give-up:** from scenario 2, apply misses.
   - Miss 1: est 112, x_out 120, state 3.
   - Miss 2: est 116. Miss 3: est 120.
   - Miss 4: state 0, 320/240, spi 0.
   - Detection at miss 2 instead → state 2, est = meas, vx stays 4.
5. **Clamp:** track at x = 630 with vx = 8 → x_out 639. Track at x = 5 with vx = −8 → x_out 0. A measured jump of +100 → vx = 16.
6. **EMA and decay:** with V_EMA_SHIFT=3 and measured +16 from vx = 0 → vx = 2. With DECAY_SHIFT=1 and vx = 16, a coasted tick → vx = 8. Also assert reset mid-COAST → immediate 320/240, state 0.
